// File: rtl/clk_1mhz_monitor.sv
// Monitors the divided 1 MHz clock in the 50 MHz domain: half-period measurement, lock, error, stuck.
// Optional duty-cycle checker enabled by defining CLKMON_DUTY_EN (adds output dutyErrO).
module clk_1mhz_monitor #(
   parameter int HALF_NOM = 24,
   parameter int TOL      = 1,
   parameter int LOCK_CNT = 4,
   parameter int CNT_W    = 8
) (
   input  logic             clk50mhzI,
   input  logic             nRstI,
   input  logic             clkInI,
   input  logic             enI,
   input  logic             errClrI,
   output logic [CNT_W-1:0] halfLenO,
   output logic             halfValidO,
   output logic             lockO,
   output logic             errO,
`ifdef CLKMON_DUTY_EN
   output logic             dutyErrO,
`endif
   output logic             stuckO
);

   localparam int GOOD_W = $clog2(LOCK_CNT + 1);
   localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
   localparam logic [CNT_W-1:0]  CNT_TO   = CNT_MAX - 1'b1;
   localparam logic [CNT_W-1:0]  LEN_LO   = CNT_W'(HALF_NOM - TOL);
   localparam logic [CNT_W-1:0]  LEN_HI   = CNT_W'(HALF_NOM + TOL);
   localparam logic [GOOD_W-1:0] GOOD_TOP = GOOD_W'(LOCK_CNT - 1);

   typedef enum logic [1:0] {IDLE, ACQ, TRACK, LOCKED} state_t;

   state_t            r_state;
   logic              r_s1, r_s2, r_s3;
   logic [CNT_W-1:0]  r_cnt;
   logic [GOOD_W-1:0] r_good;

   state_t            w_stateNxt;
   logic [CNT_W-1:0]  w_cntNxt, w_lenNxt, w_len;
   logic [GOOD_W-1:0] w_goodNxt;
   logic              w_edge, w_inRange, w_timeout;
   logic              w_validNxt, w_lockNxt, w_stuckNxt, w_errSet;

   assign w_edge    = r_s2 ^ r_s3;
   assign w_len     = (r_cnt == CNT_MAX) ? CNT_MAX : r_cnt + 1'b1;
   assign w_inRange = (w_len >= LEN_LO) && (w_len <= LEN_HI);
   // Fires on the cycle the counter steps onto its saturation value.
   assign w_timeout = !w_edge && (r_cnt == CNT_TO);

   always_comb begin
      w_stateNxt = r_state;
      w_cntNxt   = w_edge ? '0 : ((r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1);
      w_goodNxt  = r_good;
      w_lenNxt   = halfLenO;
      w_validNxt = 1'b0;
      w_lockNxt  = lockO;
      w_stuckNxt = stuckO & ~w_edge;
      w_errSet   = 1'b0;
      case (r_state)
         IDLE: begin
            w_cntNxt   = '0;
            w_goodNxt  = '0;
            w_lockNxt  = 1'b0;
            w_stuckNxt = 1'b0;
            if (enI) w_stateNxt = ACQ;
         end
         ACQ: begin
            if (w_edge) begin
               w_stateNxt = TRACK;
               w_goodNxt  = '0;
            end else if (w_timeout) begin
               w_stuckNxt = 1'b1;
               w_errSet   = 1'b1;
            end
         end
         TRACK, LOCKED: begin
            if (w_edge) begin
               w_lenNxt   = w_len;
               w_validNxt = 1'b1;
               if (w_inRange) begin
                  if (r_state == TRACK) begin
                     w_goodNxt = r_good + 1'b1;
                     if (r_good == GOOD_TOP) begin
                        w_stateNxt = LOCKED;
                        w_lockNxt  = 1'b1;
                     end
                  end
               end else begin
                  w_stateNxt = TRACK;
                  w_goodNxt  = '0;
                  w_lockNxt  = 1'b0;
                  w_errSet   = 1'b1;
               end
            end else if (w_timeout) begin
               w_stateNxt = ACQ;
               w_goodNxt  = '0;
               w_lockNxt  = 1'b0;
               w_stuckNxt = 1'b1;
               w_errSet   = 1'b1;
            end
         end
         default: w_stateNxt = IDLE;
      endcase
      // Disable overrides everything except the retained length and sticky error.
      if (!enI) begin
         w_stateNxt = IDLE;
         w_cntNxt   = '0;
         w_goodNxt  = '0;
         w_lenNxt   = halfLenO;
         w_validNxt = 1'b0;
         w_lockNxt  = 1'b0;
         w_stuckNxt = 1'b0;
         w_errSet   = 1'b0;
      end
   end

   always_ff @(posedge clk50mhzI) begin
      if (!nRstI) begin
         r_state    <= IDLE;
         r_s1       <= 1'b0;
         r_s2       <= 1'b0;
         r_s3       <= 1'b0;
         r_cnt      <= '0;
         r_good     <= '0;
         halfLenO   <= '0;
         halfValidO <= 1'b0;
         lockO      <= 1'b0;
         errO       <= 1'b0;
         stuckO     <= 1'b0;
      end else begin
         r_state    <= w_stateNxt;
         r_s1       <= clkInI;
         r_s2       <= r_s1;
         r_s3       <= r_s2;
         r_cnt      <= w_cntNxt;
         r_good     <= w_goodNxt;
         halfLenO   <= w_lenNxt;
         halfValidO <= w_validNxt;
         lockO      <= w_lockNxt;
         errO       <= w_errSet | (errO & ~errClrI);
         stuckO     <= w_stuckNxt;
      end
   end

`ifdef CLKMON_DUTY_EN
   logic [CNT_W-1:0] r_highLen, r_lowLen;
   logic             r_highVld, r_lowVld;
   logic [CNT_W-1:0] w_other, w_diff;
   logic             w_otherVld, w_dutySet, w_pairClr;

   // r_s2 low on an edge means a high half just ended, so compare against the stored low half.
   assign w_other    = r_s2 ? r_highLen : r_lowLen;
   assign w_otherVld = r_s2 ? r_highVld : r_lowVld;
   assign w_diff     = (w_len > w_other) ? w_len - w_other : w_other - w_len;
   assign w_dutySet  = w_validNxt && w_otherVld && (w_diff > CNT_W'(2 * TOL));
   assign w_pairClr  = (w_stateNxt == IDLE) || (w_stateNxt == ACQ);

   always_ff @(posedge clk50mhzI) begin
      if (!nRstI) begin
         r_highVld <= 1'b0;
         r_lowVld  <= 1'b0;
         dutyErrO  <= 1'b0;
      end else begin
         dutyErrO <= w_dutySet | (dutyErrO & ~errClrI);
         if (w_pairClr) begin
            r_highVld <= 1'b0;
            r_lowVld  <= 1'b0;
         end else if (w_validNxt && !r_s2) begin
            r_highVld <= 1'b1;
         end else if (w_validNxt) begin
            r_lowVld <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk50mhzI) begin
      if (w_validNxt && !r_s2) r_highLen <= w_len;
      if (w_validNxt && r_s2)  r_lowLen  <= w_len;
   end
`endif

endmodule

// File: tb/tb_clk_1mhz_monitor.sv
// Directed + randomized bench for clk_1mhz_monitor with a half-period-level reference model.
// Define CLKMON_DUTY_EN to also exercise dutyErrO.
module tb_clk_1mhz_monitor;
   logic       clk50mhzI = 1'b0;
   logic       nRstI, clkInI, enI, errClrI;
   logic [7:0] halfLenO;
   logic       halfValidO, lockO, errO, stuckO;
`ifdef CLKMON_DUTY_EN
   logic       dutyErrO;
`endif

   int n_assert = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int last_tgl = 0;
   // model of the monitor at the level of completed half-periods
   bit m_acq, m_lock, m_err, m_duty, m_hiVld, m_loVld;
   int m_good, m_len, m_hi, m_lo;

   clk_1mhz_monitor dut (
      .clk50mhzI (clk50mhzI),
      .nRstI     (nRstI),
      .clkInI    (clkInI),
      .enI       (enI),
      .errClrI   (errClrI),
      .halfLenO  (halfLenO),
      .halfValidO(halfValidO),
      .lockO     (lockO),
      .errO      (errO),
`ifdef CLKMON_DUTY_EN
      .dutyErrO  (dutyErrO),
`endif
      .stuckO    (stuckO)
   );

   always #5 clk50mhzI = ~clk50mhzI;

   task automatic tick();
      @(posedge clk50mhzI);
      #1;
      cyc++;
   endtask

   task automatic wait_cycles(int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      m_acq   = 1'b1;
      m_good  = 0;
      m_lock  = 1'b0;
      m_hiVld = 1'b0;
      m_loVld = 1'b0;
   endtask

   // Toggle clkInI, predict the resulting half-period report, check it 3 cycles later.
   task automatic tgl(bit clr_on_edge);
      int  sp;
      bit  lvl, ev, eset, dset;
      lvl      = clkInI;
      clkInI   = ~clkInI;
      sp       = cyc - last_tgl;
      last_tgl = cyc;
      ev = 0; eset = 0; dset = 0;
      if (m_acq) m_acq = 0;
      else begin
         ev    = 1;
         m_len = (sp > 255) ? 255 : sp;
         if (m_len >= 23 && m_len <= 25) begin
            m_good++;
            if (m_good >= 4) m_lock = 1;
         end else begin
            m_good = 0;
            m_lock = 0;
            eset   = 1;
         end
         if (lvl) begin m_hi = m_len; m_hiVld = 1; end
         else     begin m_lo = m_len; m_loVld = 1; end
         if (m_hiVld && m_loVld && (m_hi - m_lo > 2 || m_lo - m_hi > 2)) dset = 1;
      end
      m_err  = eset ? 1'b1 : (clr_on_edge ? 1'b0 : m_err);
      m_duty = dset ? 1'b1 : (clr_on_edge ? 1'b0 : m_duty);
      wait_cycles(2);
      errClrI = clr_on_edge;
      tick();
      errClrI = 1'b0;
      chk("half_valid", 32'(halfValidO), 32'(ev));
      if (ev) chk("half_len", 32'(halfLenO), 32'(m_len));
      chk("lock", 32'(lockO), 32'(m_lock));
      chk("err", 32'(errO), 32'(m_err));
      chk("stuck", 32'(stuckO), 32'(0));
`ifdef CLKMON_DUTY_EN
      chk("duty_err", 32'(dutyErrO), 32'(m_duty));
`endif
      tick();
      chk("valid_pulse_width", 32'(halfValidO), 32'(0));
   endtask

   task automatic half(int len);
      tgl(1'b0);
      wait_cycles(len - 4);
   endtask

   task automatic clear_err();
      errClrI = 1'b1;
      tick();
      errClrI = 1'b0;
      m_err  = 0;
      m_duty = 0;
      chk("err_clear", 32'(errO), 32'(0));
   endtask

   initial begin
      nRstI = 1'b0; clkInI = 1'b0; enI = 1'b1; errClrI = 1'b0;
      m_err = 0; m_duty = 0; m_hi = 0; m_lo = 0; m_len = 0;
      model_clear();

      // 1: reset with clkInI toggling
      for (int i = 0; i < 5; i++) begin
         clkInI = ~clkInI;
         tick();
         chk("reset_outputs", 32'({halfLenO, halfValidO, lockO, errO, stuckO}), 32'(0));
      end
      clkInI = 1'b0;
      enI    = 1'b0;
      tick();
      nRstI = 1'b1;
      wait_cycles(4);
      chk("idle_outputs", 32'({halfLenO, halfValidO, lockO, errO, stuckO}), 32'(0));
      enI = 1'b1;
      wait_cycles(3);

      // 2: nominal 24-cycle halves, first edge discarded, lock on 4th report
      for (int i = 0; i < 6; i++) half(24);

      // 3: 27-cycle halves break lock; standalone clear works; clear on a bad edge loses
      for (int i = 0; i < 3; i++) half(27);
      tgl(1'b0);
      clear_err();
      wait_cycles(27 - 5);
      tgl(1'b1);
      wait_cycles(24 - 4);

      // 4: relock, then stuck clock and recovery
      for (int i = 0; i < 5; i++) half(24);
      chk("locked_before_stuck", 32'(lockO), 32'(1));
      tgl(1'b0);
      wait_cycles(253);
      chk("stuck_not_yet", 32'(stuckO), 32'(0));
      tick();
      chk("stuck_set", 32'(stuckO), 32'(1));
      chk("stuck_lock", 32'(lockO), 32'(0));
      chk("stuck_err", 32'(errO), 32'(1));
      model_clear();
      m_err = 1;
      wait_cycles(42);
      for (int i = 0; i < 6; i++) half(24);

      // 5: one-cycle disable while locked
      chk("locked_before_disable", 32'(lockO), 32'(1));
      tgl(1'b0);
      enI = 1'b0;
      tick();
      chk("disable_lock", 32'(lockO), 32'(0));
      chk("disable_len_kept", 32'(halfLenO), 32'(24));
      chk("disable_valid", 32'(halfValidO), 32'(0));
      enI = 1'b1;
      model_clear();
      wait_cycles(24 - 6);
      for (int i = 0; i < 5; i++) half(24);

      // randomized half-period lengths around nominal
      for (int i = 0; i < 24; i++) half(int'($urandom_range(21, 27)));

`ifdef CLKMON_DUTY_EN
      // 6: asymmetric duty then balanced duty after clearing
      clear_err();
      for (int i = 0; i < 6; i++) begin
         tgl(1'b0);
         wait_cycles((clkInI ? 22 : 26) - 4);
      end
      chk("duty_asym", 32'(dutyErrO), 32'(1));
      clear_err();
      chk("duty_cleared", 32'(dutyErrO), 32'(0));
      for (int i = 0; i < 6; i++) half(24);
`endif

      // reset mid-measurement: no report may follow
      clkInI = ~clkInI;
      tick();
      nRstI = 1'b0;
      tick();
      nRstI = 1'b1;
      chk("midreset_outputs", 32'({halfLenO, halfValidO, lockO, errO, stuckO}), 32'(0));
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("midreset_no_valid", 32'(halfValidO), 32'(0));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
